// File: rtl/msx_joy_router_pkg.sv
// msx_joy_pkg: shared bit indices, port vector type, hold FSM states and the
// direction-mapping helper used by the joystick router.
package msx_joy_pkg;

  localparam int unsigned HOST_W      = 16;  // width of one mist_io joystick word
  localparam int unsigned HOST_USED_W = 8;   // low bits actually consumed
  localparam int unsigned PORT_W      = 6;   // width of one MSX joystick port

  // Host word bit positions (active high)
  localparam int unsigned JB_RIGHT  = 0;
  localparam int unsigned JB_LEFT   = 1;
  localparam int unsigned JB_DOWN   = 2;
  localparam int unsigned JB_UP     = 3;
  localparam int unsigned JB_BTNA   = 4;
  localparam int unsigned JB_BTNB   = 5;
  localparam int unsigned JB_TURBOA = 6;
  localparam int unsigned JB_TURBOB = 7;

  // MSX port bit positions (pins are active low)
  localparam int unsigned JP_UP    = 0;
  localparam int unsigned JP_DOWN  = 1;
  localparam int unsigned JP_LEFT  = 2;
  localparam int unsigned JP_RIGHT = 3;
  localparam int unsigned JP_P6    = 4;
  localparam int unsigned JP_P9    = 5;

  localparam logic [1:0] AF_RATE_HOLD = 2'd3;

  typedef logic [PORT_W-1:0] port_vec_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } hold_state_t;

  // Active-high direction bits for one port; opposite pairs cancel when neutral.
  function automatic port_vec_t map_dirs(input logic [HOST_USED_W-1:0] h,
                                         input bit socd_neutral);
    port_vec_t v;
    logic      ud;
    logic      lr;
    v  = '0;
    ud = socd_neutral & h[JB_UP] & h[JB_DOWN];
    lr = socd_neutral & h[JB_LEFT] & h[JB_RIGHT];
    v[JP_UP]    = h[JB_UP]    & ~ud;
    v[JP_DOWN]  = h[JB_DOWN]  & ~ud;
    v[JP_LEFT]  = h[JB_LEFT]  & ~lr;
    v[JP_RIGHT] = h[JB_RIGHT] & ~lr;
    return v;
  endfunction

endpackage

// File: rtl/msx_joy_router_if.sv
// msx_joy_router_if: bus between mist_io side and the joystick router.
//   joy_host_i   host joystick words (active high)
//   route_sel_i  host index per MSX port
//   swap_i       exchange selectors of ports 0 and 1
//   af_rate_i    autofire rate (3 = plain hold)
//   joy_port_n_o MSX port pins, active low
//   hold_o       idle hold after a routing change
interface msx_joy_router_if
  import msx_joy_pkg::*;
#(
  parameter int unsigned NUM_HOST = 2,
  parameter int unsigned NUM_PORT = 2,
  parameter int unsigned SEL_W    = 2
);
  logic [NUM_HOST*HOST_W-1:0] joy_host_i;
  logic [NUM_PORT*SEL_W-1:0]  route_sel_i;
  logic                       swap_i;
  logic [1:0]                 af_rate_i;
  logic [NUM_PORT*PORT_W-1:0] joy_port_n_o;
  logic                       hold_o;

  modport master (
    output joy_host_i, route_sel_i, swap_i, af_rate_i,
    input  joy_port_n_o, hold_o
  );

  modport slave (
    input  joy_host_i, route_sel_i, swap_i, af_rate_i,
    output joy_port_n_o, hold_o
  );
endinterface

// File: rtl/msx_joy_router_autofire.sv
// msx_autofire: one turbo button. 3-bit counter cleared on turbo press,
// advanced by the shared prescaler tick while held; the selected counter bit
// gates the fire output (phase 0 = asserted, so a press fires immediately).
//   clk_sys, reset_n  clock, synchronous active-low reset
//   tick_i            prescaler tick
//   turbo_i           stage-1 turbo bit of the routed host
//   rate_i            0..2 phase bit select, 3 = continuous
//   fire_c            combinational turbo result, registered by the router
module msx_autofire
  import msx_joy_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       tick_i,
  input  logic       turbo_i,
  input  logic [1:0] rate_i,
  output logic       fire_c
);

  logic       turbo_q;
  logic [2:0] cnt_q;
  logic [2:0] cnt_eff;
  logic       rise;
  logic       phase;

  // Phase uses the cleared count during the press cycle so the first shot is immediate.
  always_comb begin
    rise    = turbo_i & ~turbo_q;
    cnt_eff = rise ? 3'd0 : cnt_q;
    phase   = 1'b0;
    case (rate_i)
      2'd0:    phase = cnt_eff[0];
      2'd1:    phase = cnt_eff[1];
      2'd2:    phase = cnt_eff[2];
      default: phase = 1'b0;
    endcase
    fire_c = turbo_i & ((rate_i == AF_RATE_HOLD) | ~phase);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      turbo_q <= 1'b0;
      cnt_q   <= 3'd0;
    end else begin
      turbo_q <= turbo_i;
      if (rise) begin
        cnt_q <= 3'd0;
      end else if (tick_i && turbo_i) begin
        cnt_q <= cnt_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/msx_joy_router.sv
// msx_joy_router: routes NUM_HOST mist_io joystick words onto NUM_PORT MSX
// joystick ports with input registering, opposite-direction suppression,
// per-port autofire and an idle hold whenever the routing changes.
//   clk_sys  system clock
//   reset_n  synchronous reset, active low
//   bus      msx_joy_router_if slave: host words, selectors, swap, autofire
//            rate in; active-low port pins and hold flag out (all registered)
module msx_joy_router
  import msx_joy_pkg::*;
#(
  parameter int unsigned NUM_HOST     = 2,
  parameter int unsigned NUM_PORT     = 2,
  parameter int unsigned SEL_W        = 2,
  parameter int unsigned AF_PRESC_W   = 18,
  parameter int unsigned HOLD_CYCLES  = 1024,
  parameter bit          SOCD_NEUTRAL = 1'b1
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  msx_joy_router_if.slave  bus
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  // Partner of port 0 for swapping; degenerates to port 0 itself with a single port.
  localparam int unsigned P1 = (NUM_PORT >= 2) ? 1 : 0;

  logic [NUM_HOST*HOST_USED_W-1:0] host_q;
  logic [SEL_W-1:0]                sel_eff  [NUM_PORT];
  logic [SEL_W-1:0]                route_q  [NUM_PORT];
  logic [HOST_USED_W-1:0]          sel_word [NUM_PORT];
  logic                            route_chg;
  hold_state_t                     state_q, state_d;
  logic [HOLD_W-1:0]               hold_cnt_q, hold_cnt_d;
  logic [AF_PRESC_W-1:0]           presc_q;
  logic                            tick_c;
  logic [NUM_PORT-1:0]             fire_a_c;
  logic [NUM_PORT-1:0]             fire_b_c;
  logic [NUM_PORT*PORT_W-1:0]      port_n_q, port_n_d;
  logic                            unused_host_hi;

  // Upper host bits carry nothing for the MSX side.
  always_comb begin
    unused_host_hi = 1'b0;
    for (int h = 0; h < NUM_HOST; h++) begin
      unused_host_hi = unused_host_hi ^ (^bus.joy_host_i[h*HOST_W+HOST_USED_W +: HOST_W-HOST_USED_W]);
    end
  end

  // Effective selectors with the port 0/1 swap applied.
  always_comb begin
    for (int p = 0; p < NUM_PORT; p++) begin
      sel_eff[p] = bus.route_sel_i[p*SEL_W +: SEL_W];
    end
    if (bus.swap_i) begin
      sel_eff[0]  = bus.route_sel_i[P1*SEL_W +: SEL_W];
      sel_eff[P1] = bus.route_sel_i[0 +: SEL_W];
    end
  end

  always_comb begin
    route_chg = 1'b0;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (sel_eff[p] != route_q[p]) route_chg = 1'b1;
    end
  end

  // Host word per port; out-of-range selectors yield an idle (all-zero) word.
  always_comb begin
    for (int p = 0; p < NUM_PORT; p++) begin
      sel_word[p] = '0;
      for (int h = 0; h < NUM_HOST; h++) begin
        if (route_q[p] == SEL_W'(h)) sel_word[p] = host_q[h*HOST_USED_W +: HOST_USED_W];
      end
    end
  end

  assign tick_c = &presc_q;

  for (genvar p = 0; p < NUM_PORT; p++) begin : g_port
    msx_autofire u_af_a (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .tick_i  (tick_c),
      .turbo_i (sel_word[p][JB_TURBOA]),
      .rate_i  (bus.af_rate_i),
      .fire_c  (fire_a_c[p])
    );
    msx_autofire u_af_b (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .tick_i  (tick_c),
      .turbo_i (sel_word[p][JB_TURBOB]),
      .rate_i  (bus.af_rate_i),
      .fire_c  (fire_b_c[p])
    );
  end

  // Hold FSM next state; a routing change (re)starts the hold.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    if (route_chg) begin
      state_d    = ST_HOLD;
      hold_cnt_d = HOLD_W'(HOLD_CYCLES - 1);
    end else if (state_q == ST_HOLD) begin
      if (hold_cnt_q == '0) begin
        state_d = ST_RUN;
      end else begin
        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
      end
    end
  end

  // Stage-2 port data; idle whenever the next state is a hold.
  always_comb begin
    port_vec_t v;
    v        = '0;
    port_n_d = '1;
    if (state_d == ST_RUN) begin
      for (int p = 0; p < NUM_PORT; p++) begin
        v        = map_dirs(sel_word[p], SOCD_NEUTRAL);
        v[JP_P6] = sel_word[p][JB_BTNA] | fire_a_c[p];
        v[JP_P9] = sel_word[p][JB_BTNB] | fire_b_c[p];
        port_n_d[p*PORT_W +: PORT_W] = ~v;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      host_q     <= '0;
      state_q    <= ST_RUN;
      hold_cnt_q <= '0;
      presc_q    <= '0;
      port_n_q   <= '1;
      for (int p = 0; p < NUM_PORT; p++) route_q[p] <= sel_eff[p];
    end else begin
      for (int h = 0; h < NUM_HOST; h++) begin
        host_q[h*HOST_USED_W +: HOST_USED_W] <= bus.joy_host_i[h*HOST_W +: HOST_USED_W];
      end
      if (route_chg) begin
        for (int p = 0; p < NUM_PORT; p++) route_q[p] <= sel_eff[p];
      end
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      presc_q    <= presc_q + AF_PRESC_W'(1);
      port_n_q   <= port_n_d;
    end
  end

  assign bus.joy_port_n_o = port_n_q;
  assign bus.hold_o       = (state_q == ST_HOLD);

endmodule

// File: tb/tb_msx_joy_router.sv
// tb_msx_joy_router: directed bench for msx_joy_router. Two instances share
// stimulus and differ only in SOCD_NEUTRAL; a short hold and a 4-bit
// prescaler keep timing windows small.
module tb_msx_joy_router;

  localparam int unsigned HOLD = 16;

  logic clk_sys;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  msx_joy_router_if #(.NUM_HOST(2), .NUM_PORT(2), .SEL_W(2)) bus_a ();
  msx_joy_router_if #(.NUM_HOST(2), .NUM_PORT(2), .SEL_W(2)) bus_b ();

  msx_joy_router #(
    .NUM_HOST(2), .NUM_PORT(2), .SEL_W(2), .AF_PRESC_W(4),
    .HOLD_CYCLES(HOLD), .SOCD_NEUTRAL(1'b1)
  ) dut_a (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  msx_joy_router #(
    .NUM_HOST(2), .NUM_PORT(2), .SEL_W(2), .AF_PRESC_W(4),
    .HOLD_CYCLES(HOLD), .SOCD_NEUTRAL(1'b0)
  ) dut_b (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic set_host(input logic [15:0] h0, input logic [15:0] h1);
    bus_a.joy_host_i = {h1, h0};
    bus_b.joy_host_i = {h1, h0};
  endtask

  task automatic set_route(input logic [3:0] sel, input logic swap);
    bus_a.route_sel_i = sel;
    bus_b.route_sel_i = sel;
    bus_a.swap_i      = swap;
    bus_b.swap_i      = swap;
  endtask

  task automatic set_rate(input logic [1:0] r);
    bus_a.af_rate_i = r;
    bus_b.af_rate_i = r;
  endtask

  // Counts hold cycles (bounded) and any non-idle output seen during them.
  task automatic wait_hold(output int len, output int bad);
    len = 0;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (bus_a.hold_o) begin
        len++;
        if (bus_a.joy_port_n_o !== 12'hFFF) bad++;
      end else begin
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int bad;
    int highs;
    int tt[$];
    logic prev;
    logic cur;

    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    set_host(16'h00FF, 16'h0000);
    set_route(4'b0100, 1'b0);
    set_rate(2'd0);

    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("rst_port", 32'(bus_a.joy_port_n_o), 32'hFFF);
      chk("rst_hold", 32'(bus_a.hold_o), 32'h0);
    end
    reset_n = 1'b1;
    step(1);
    chk("post_rst_port", 32'(bus_a.joy_port_n_o), 32'hFFF);
    chk("post_rst_hold", 32'(bus_a.hold_o), 32'h0);

    // Basic route: host0 up reaches port0 after two edges
    set_host(16'h0000, 16'h0000);
    step(3);
    set_host(16'h0008, 16'h0000);
    step(1);
    chk("lat_1cyc", 32'(bus_a.joy_port_n_o[5:0]), 32'h3F);
    step(1);
    chk("basic_p0", 32'(bus_a.joy_port_n_o[5:0]), 32'h3E);
    chk("basic_p1", 32'(bus_a.joy_port_n_o[11:6]), 32'h3F);
    set_host(16'h0008, 16'h0011);
    step(2);
    chk("basic_p1_rt_a", 32'(bus_a.joy_port_n_o[11:6]), 32'h27);

    // SOCD resolution
    set_host(16'h000C, 16'h0011);
    step(2);
    chk("socd_ud_neutral", 32'(bus_a.joy_port_n_o[1:0]), 32'h3);
    chk("socd_ud_pass", 32'(bus_b.joy_port_n_o[1:0]), 32'h0);
    set_host(16'h0003, 16'h0011);
    step(2);
    chk("socd_lr_neutral", 32'(bus_a.joy_port_n_o[3:2]), 32'h3);
    chk("socd_lr_pass", 32'(bus_b.joy_port_n_o[3:2]), 32'h0);

    // Swap toggle: idle hold then host0 appears on port1
    set_host(16'h0008, 16'h0011);
    step(2);
    set_route(4'b0100, 1'b1);
    wait_hold(len, bad);
    chk("swap_hold_len", 32'(len), 32'(HOLD));
    chk("swap_hold_idle", 32'(bad), 32'h0);
    chk("swap_p1", 32'(bus_a.joy_port_n_o[11:6]), 32'h3E);
    chk("swap_p0", 32'(bus_a.joy_port_n_o[5:0]), 32'h27);
    set_route(4'b0100, 1'b0);
    wait_hold(len, bad);
    chk("unswap_hold_len", 32'(len), 32'(HOLD));

    // Selector beyond NUM_HOST leaves the port idle
    set_route(4'b1100, 1'b0);
    wait_hold(len, bad);
    chk("sel3_hold_len", 32'(len), 32'(HOLD));
    chk("sel3_p1_idle", 32'(bus_a.joy_port_n_o[11:6]), 32'h3F);
    chk("sel3_p0", 32'(bus_a.joy_port_n_o[5:0]), 32'h3E);

    // Change during the hold restarts it
    set_route(4'b0100, 1'b0);
    step(5);
    chk("midhold_active", 32'(bus_a.hold_o), 32'h1);
    set_route(4'b0000, 1'b0);
    wait_hold(len, bad);
    chk("midhold_restart_len", 32'(len), 32'(HOLD));
    chk("midhold_idle", 32'(bad), 32'h0);
    chk("midhold_p1_host0", 32'(bus_a.joy_port_n_o[11:6]), 32'h3E);
    set_route(4'b0100, 1'b0);
    wait_hold(len, bad);

    // Autofire rate 0: immediate shot then toggle every 16 cycles
    set_host(16'h0000, 16'h0000);
    step(3);
    set_rate(2'd0);
    set_host(16'h0040, 16'h0000);
    step(1);
    chk("af_lat_1cyc", 32'(bus_a.joy_port_n_o[5:0]), 32'h3F);
    step(1);
    chk("af_first_shot", 32'(bus_a.joy_port_n_o[5:0]), 32'h2F);
    prev = bus_a.joy_port_n_o[4];
    for (int i = 0; i < 100; i++) begin
      step(1);
      cur = bus_a.joy_port_n_o[4];
      if (cur !== prev) tt.push_back(i);
      prev = cur;
    end
    chk("af_toggle_count_ge4", 32'(tt.size() >= 4), 32'h1);
    for (int k = 1; k < 4; k++) begin
      if (k < tt.size()) chk("af_period", 32'(tt[k] - tt[k-1]), 32'd16);
    end

    // Reset pulse mid-autofire
    reset_n = 1'b0;
    step(1);
    chk("af_rst_port", 32'(bus_a.joy_port_n_o), 32'hFFF);
    chk("af_rst_hold", 32'(bus_a.hold_o), 32'h0);
    reset_n = 1'b1;
    step(1);
    chk("af_rst_rel1", 32'(bus_a.joy_port_n_o[5:0]), 32'h3F);
    step(1);
    chk("af_rst_rel2", 32'(bus_a.joy_port_n_o[5:0]), 32'h2F);

    // Rate 3: turbo behaves as a plain hold
    set_host(16'h0000, 16'h0000);
    step(3);
    chk("af_release", 32'(bus_a.joy_port_n_o[5:0]), 32'h3F);
    set_rate(2'd3);
    set_host(16'h0040, 16'h0000);
    step(2);
    chk("af3_press", 32'(bus_a.joy_port_n_o[5:0]), 32'h2F);
    highs = 0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (bus_a.joy_port_n_o[4] !== 1'b0) highs++;
    end
    chk("af3_steady", 32'(highs), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/msx_joy_router.md
Name: msx_joy_router

Overview:
- Parametrised successor to the fixed two-joystick swap path between the mist_io joystick words and the MSX core's active-low joystick pins.
- Routes any of NUM_HOST host joystick words to any of NUM_PORT MSX ports.
- Adds input registering, opposite-direction suppression, per-port autofire, and a glitch-free idle hold whenever routing changes.
- Sits between mist_io and the MSX core in the board top, clocked by the system clock.

Parameters:
- NUM_HOST, 2, number of 16-bit host joystick words.
- NUM_PORT, 2, number of MSX joystick ports driven.
- SEL_W, 2, width of each per-port route selector.
- AF_PRESC_W, 18, autofire prescaler width; one tick every 2^AF_PRESC_W cycles.
- HOLD_CYCLES, 1024, idle-hold length after a routing change.
- SOCD_NEUTRAL, 1, when 1 an up+down or left+right pair resolves to neither direction.

Ports:
- clk_sys  in  1  system clock (21.477 MHz)
- reset_n  in  1  synchronous reset, active low
- joy_host_i  in  NUM_HOST*16  host words, active high; bits: [0]right [1]left [2]down [3]up [4]btnA [5]btnB [6]turboA [7]turboB; others ignored
- route_sel_i  in  NUM_PORT*SEL_W  host index for each port
- swap_i  in  1  interchanges the selectors of ports 0 and 1 (no effect if NUM_PORT<2)
- af_rate_i  in  2  autofire rate: 0 fastest, 1, 2 slowest, 3 = turbo acts as plain hold
- joy_port_n_o  out  NUM_PORT*6  per port, active low: [0]up [1]down [2]left [3]right [4]p6 [5]p9
- hold_o  out  1  high while the idle hold is active

Behaviour:
- Reset (reset_n=0 at a clk_sys edge):
  - all joy_port_n_o = 1; hold_o = 0.
  - route registers = route_sel_i sampled with swap applied; prescaler and autofire counters cleared.
  - Reset applied mid-operation takes effect at the next edge with the same values.
- Pipeline:
  - stage 1 registers joy_host_i.
  - stage 2 registers the mapped port outputs.
  - Latency from host bit change to pin change = 2 cycles (non-turbo path).
- Effective selector: sel_eff[p] = route_sel_i[p], except when swap_i=1 and NUM_PORT>=2, in which case ports 0 and 1 use each other's selector.
- Routing change:
  - Any cycle where sel_eff differs from the route registers: load the route registers, load the hold counter with HOLD_CYCLES-1, set hold_o=1.
  - While hold_o=1, all outputs are 1.
  - hold_o clears in the cycle after the counter reaches 0.
  - A further change during the hold reloads the counter (restart).
- Selector >= NUM_HOST: that port stays all-1 (idle), no error flag.
- SOCD_NEUTRAL=1: up&down both set drives neither; left&right both set drives neither. SOCD_NEUTRAL=0: pass through unchanged.
- Autofire:
  - Prescaler: free-running AF_PRESC_W-bit counter; tick when it wraps to 0.
  - Each port has a 3-bit counter per turbo button.
    - Cleared on the rising edge of the turbo bit (stage-1 value).
    - Increments on each tick while the turbo bit is held.
    - Wraps 7 -> 0.
  - Phase bit: rate 0 -> cnt[0], rate 1 -> cnt[1], rate 2 -> cnt[2].
  - Turbo pressed and phase=0 -> button asserted; phase=1 -> released. The first press therefore asserts immediately.
  - Rate 3: turbo asserts continuously while held.
  - p6 = btnA OR turboA-result; p9 = btnB OR turboB-result.
  - af_rate_i changes take effect on the next cycle with no counter reset.
- Simultaneous host change and routing change: the routing change wins (hold); host data is ignored until the hold ends.
- Outputs are glitch-free registered signals; nothing combinational goes from input to output.

Decomposition:
- Shared package (msx_joy_pkg):
  - host bit index constants (JB_RIGHT..JB_TURBOB).
  - port bit index constants (JP_UP..JP_P9).
  - AF_RATE_HOLD = 2'd3.
  - typedef for the 6-bit port vector.
- One sub-module: msx_autofire, holding the per-button 3-bit counter, edge detect and phase select. It is instantiated 2*NUM_PORT times and shares the prescaler tick input.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with host0 = 16'h00FF -> all joy_port_n_o = 1 and hold_o = 0 during reset and in the first cycle after.
- Basic route: sel = {1,0}, swap = 0, after the hold expires, host0 = 16'h0008 (up) -> port0 bit0 = 0 exactly 2 cycles later; port1 = 6'h3F.
- Swap toggle: set swap_i 0 -> 1 -> hold_o = 1 for HOLD_CYCLES cycles with outputs all-1. Then host0 up appears on port1 bit0 = 0.
- SOCD: host0 = 16'h000C (up+down) with SOCD_NEUTRAL=1 -> port0 bits[1:0] = 2'b11. Repeat with SOCD_NEUTRAL=0 -> 2'b00.
- Autofire: AF_PRESC_W=4, rate 0, hold turboA -> p6 low immediately (2 cycles), then toggles every 16 cycles. Rate 3 -> p6 stays low for the whole press.
- Edge cases:
  - Selector = 3 with NUM_HOST=2 -> that port is all-1.
  - Selector change mid-hold -> hold restarts at HOLD_CYCLES.
  - reset_n pulsed mid-autofire -> outputs return to all-1 at the next edge.
